// File: rtl/rev_counter_cascade.sv
// rev_counter_cascade: reversible counter stage fed by an upstream ripple carry.
// Counts only when ci is high. Supports a synchronous saturating load and
// sticky overflow/underflow flags. co is combinational so that chained stages
// all advance on the same clock edge.
module rev_counter_cascade #(
  parameter int WIDTH = 16,
  parameter int MOD   = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ci,
  input  logic             s,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             co,
  output logic             ovf,
  output logic             unf
);

  // Largest legal count. When MOD equals 2^WIDTH this is all ones, and the
  // wrap becomes plain binary overflow.
  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_din_clamped;
  logic [WIDTH-1:0] w_cnt_up;
  logic [WIDTH-1:0] w_cnt_dn;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_wrap_up;
  logic             w_wrap_dn;
  logic             w_co;

  // Next-value candidates, wrap detection and the carry-out.
  always_comb begin
    w_din_clamped = din;
    w_cnt_up      = r_cnt + C_ONE;
    w_cnt_dn      = r_cnt - C_ONE;
    w_at_max      = (r_cnt == C_MAX);
    w_at_zero     = (r_cnt == C_ZERO);
    w_wrap_up     = 1'b0;
    w_wrap_dn     = 1'b0;
    w_co          = 1'b0;

    if (din > C_MAX) begin
      w_din_clamped = C_MAX;
    end else begin
      w_din_clamped = din;
    end

    if (w_at_max) begin
      w_cnt_up = C_ZERO;
    end else begin
      w_cnt_up = r_cnt + C_ONE;
    end

    if (w_at_zero) begin
      w_cnt_dn = C_MAX;
    end else begin
      w_cnt_dn = r_cnt - C_ONE;
    end

    // A wrap only happens on a genuine count edge (no load).
    if (ci && !ld) begin
      if (s) begin
        w_wrap_up = w_at_max;
        w_wrap_dn = 1'b0;
      end else begin
        w_wrap_up = 1'b0;
        w_wrap_dn = w_at_zero;
      end
    end else begin
      w_wrap_up = 1'b0;
      w_wrap_dn = 1'b0;
    end

    // Reset suppresses the carry so downstream stages never see a spurious count.
    if (rst) begin
      w_co = 1'b0;
    end else begin
      w_co = w_wrap_up | w_wrap_dn;
    end
  end

  // Count register and sticky flags; priority is rst > ld > ci.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= C_ZERO;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (ld) begin
        r_cnt <= w_din_clamped;
      end else if (ci) begin
        if (s) begin
          r_cnt <= w_cnt_up;
        end else begin
          r_cnt <= w_cnt_dn;
        end
      end else begin
        r_cnt <= r_cnt;
      end
      // A wrap on the same edge as clr wins, leaving the flag set.
      r_ovf <= w_wrap_up | (r_ovf & ~clr);
      r_unf <= w_wrap_dn | (r_unf & ~clr);
    end
  end

  assign cnt = r_cnt;
  assign ovf = r_ovf;
  assign unf = r_unf;
  assign co  = w_co;

endmodule

// File: doc/rev_counter_cascade.md
Name: rev_counter_cascade

Overview:
- Reversible (up/down) counter stage that sits on the consuming end of a RevCounter ripple-carry output.
- Counts only when its carry-in is asserted, so it extends a lower RevCounter stage into a wider or multi-digit count chain.
- Produces its own same-cycle carry-out, so stages can be chained without limit.
- Adds synchronous load and sticky wrap flags for overflow and underflow monitoring.

Parameters:
- WIDTH, 16, width of cnt and din.
- MOD, 65536, count modulus; legal count values are 0..MOD-1. Constraint: 2 <= MOD <= 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ci  input  1  carry-in / count enable, driven by the upstream stage's Rc.
- s  input  1  direction: 1 = up, 0 = down; same meaning as the upstream stage.
- ld  input  1  synchronous load strobe.
- din  input  WIDTH  load value.
- clr  input  1  synchronous clear of the sticky flags only.
- cnt  output  WIDTH  current count, registered.
- co  output  1  carry-out to the next stage, combinational.
- ovf  output  1  sticky flag: an up-wrap has occurred.
- unf  output  1  sticky flag: a down-wrap has occurred.

Behaviour:
- Reset: one clock only; reset is synchronous and active-high.
  - rst=1 at a clock edge sets cnt=0, ovf=0, unf=0.
  - Reset has priority over every other input, including mid-count and mid-load.
- Update priority per edge: rst > ld > ci.
- Load (ld=1):
  - cnt <= din when din <= MOD-1; otherwise cnt <= MOD-1 (saturating clamp).
  - ci is ignored that cycle; no wrap flag is set.
- Count (ld=0, ci=1):
  - s=1: cnt <= (cnt==MOD-1) ? 0 : cnt+1. On the wrap, ovf <= 1.
  - s=0: cnt <= (cnt==0) ? MOD-1 : cnt-1. On the wrap, unf <= 1.
- Hold (ld=0, ci=0): cnt holds; flags hold.
- Carry-out:
  - co = ci & ~ld & (s ? cnt==MOD-1 : cnt==0).
  - co is combinational, with zero-cycle latency, so the whole chain advances on the same edge.
  - co is never asserted during reset or load cycles; it is gated by rst as well.
- Flag clear:
  - clr=1 clears ovf and unf on the next edge.
  - If a wrap occurs in the same cycle as clr, the wrap wins and the corresponding flag reads 1 afterwards.
- Direction change: s may change on any cycle. The new direction applies at the next edge, with no settle cycle. co follows s combinationally.
- Arithmetic: all compares and increments are WIDTH bits wide. When MOD=2^WIDTH, the wrap reduces to natural binary overflow.
- No internal state beyond cnt, ovf and unf; no other latency.

Test Plan:
1. Reset: rst=1 for 2 cycles with ci=1, s=1, cnt previously 0x1234 -> cnt=0x0000, ovf=0, unf=0, co=0.
2. Up-wrap (MOD=10, WIDTH=4): load 8, then ci=1, s=1 for 3 edges.
   - cnt = 9, 0, 1.
   - co=1 only while cnt=9.
   - ovf=1 from the wrap edge onward; unf=0.
3. Down-wrap (MOD=10): load 1, then ci=1, s=0 for 3 edges.
   - cnt = 0, 9, 8.
   - co=1 only while cnt=0.
   - unf=1 afterwards.
4. Cascade: drive ci from a RevCounter Rc (WIDTH=16 both stages).
   - Up from 0xFFFE: this stage increments exactly once, on the edge where the lower stage goes 0xFFFF -> 0x0000.
   - Down from 0x0001: this stage decrements once, on the edge where the lower stage goes 0x0000 -> 0xFFFF.
   - ci=0 for 10 cycles -> cnt unchanged.
5. Priority and clamp (MOD=10):
   - ld=1, din=15, ci=1 -> cnt=9, co=0, no flag set.
   - rst=1 together with ld=1 -> cnt=0.
6. Flag clear race: cnt=9, s=1, ci=1, clr=1 on the same edge -> cnt=0, ovf=1. Next cycle clr=1, ci=0 -> ovf=0.
